csr_led_blink: RTL
==================

# csr_led_blink

CSR-programmable blink/PWM sequencer for the LED CSR. Software configures enable, polarity and on/off durations through two CSRs on the core CSR bus. The block autonomously drives the LED CSR's external write port (`ext_data`/`ext_write_enable`) with one single-cycle write strobe per level change, so the LED toggles without core involvement. It sits beside the LED CSR in the core's CSR file, and its `out` is OR-merged into the CSR read mux.

## Interface
Parameters:
- `Addr`, 12'h001: address of CTRL; TIME is at `Addr+1`.
- `Prescale`, 1: clk cycles per timing tick, ≥1.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `csr_enable` in 1: CSR instruction valid this cycle.
- `csr_addr` in `CsrAddrT` (12): CSR address.
- `rs1_zimm` in `r` (5): immediate source for CSRR*I ops.
- `rs1_data` in `word` (32): register source for CSRRW/RS/RC.
- `csr_op` in `csr_op_t`: RW, RS, RC, RWI, RSI, RCI.
- `out` out `word`: read data of the addressed register; 0 when not addressed.
- `ext_data` out 1: LED level presented to the LED CSR's external write port.
- `ext_write_enable` out 1: one-cycle write strobe to the LED CSR.
- `busy` out 1: FSM not in IDLE.

## Operation
- Registers:
  - CTRL[0] = `en`; CTRL[1] = `inv`; CTRL[31:2] read as 0 and ignore writes.
  - TIME[15:0] = `on_t`; TIME[31:16] = `off_t`, both in ticks.
- Address match: `csr_enable && csr_addr==Addr` selects CTRL; `csr_enable && csr_addr==Addr+1` selects TIME.
- Operand source:
  - `src = rs1_data` for RW/RS/RC.
  - `src = {27'b0, rs1_zimm}` for the I variants.
- Write semantics:
  - RW/RWI: reg ← src.
  - RS/RSI: reg ← reg | src.
  - RC/RCI: reg ← reg & ~src.
  - RS/RC with `src==0` do not write.
- `out` is combinational: the pre-write value of the selected register, else 0.
- Tick: a prescaler counts 0..Prescale-1 and restarts on every phase load. A phase ends after N full ticks (N×Prescale clk cycles).
- FSM states: IDLE, ON, OFF.
  - IDLE: if `en` and `on_t!=0` → ON, load on_t. If `en` and `on_t==0` → stay IDLE with LED held at the off level.
  - ON: when on_t ticks elapse: if `off_t!=0` → OFF, load off_t; else reload on_t and stay ON (steady on, no strobe).
  - OFF: when off_t ticks elapse: if `on_t!=0` → ON, load on_t; else reload off_t and stay OFF (no strobe).
  - Any state with `en==0` → IDLE.
- Strobes:
  - Each state change with a level change asserts `ext_write_enable` for exactly 1 cycle.
  - Level: `ext_data = 1^inv` when entering ON; `ext_data = 0^inv` when entering OFF or IDLE.
  - IDLE→IDLE, ON→ON and OFF→OFF produce no strobe.
- TIME writes during a phase do not affect the current phase; the new values are used at the next phase load.
- `inv` change while running: takes effect at the next strobe only.

## Timing
- Reset (async assert): CTRL=0, TIME=0, state IDLE, prescaler=0, phase counter=0, `ext_write_enable=0`, `ext_data=0`, `busy=0`. `out` is 0 unless addressed (then it reads 0).
- CSR writes land at the clock edge of the instruction cycle (edge E0).
- FSM responds at edge E1. `ext_write_enable`/`ext_data`/`busy` are registered, so the first strobe is high during the cycle after E1.
- Period: consecutive strobes are exactly `on_t×Prescale` (ON→OFF) and `off_t×Prescale` (OFF→ON) cycles apart.
- Disable: clearing `en` at E0 gives an IDLE strobe after E1, with `busy` low from that same cycle.
- Simultaneous phase end and `en` clear: the transition is to IDLE, with a single strobe at the off level.
- Counter wrap: 16-bit phase counters count down to 1 and never underflow. The maximum phase is 65535 ticks.

## Test plan
- Reset mid-blink: assert `reset` while ON → outputs all 0 immediately. No strobe after release until `en` is rewritten.
- Prescale=2, TIME=0x0003_0002 (off_t=3, on_t=2), CSRRWI CTRL=1 → strobes ext_data=1, 0, 1, … spaced 4, 6, 4 cycles; first strobe 1 cycle after the write edge.
- CSRRSI CTRL,2 while running → next strobe level is inverted. CSRRCI CTRL,1 → immediate IDLE strobe with ext_data=1 (off level with inv=1), then `busy=0`.
- TIME=0x0000_0005 (off_t=0) with en=1 → one strobe ext_data=1, then no further strobes for ≥100 cycles and `busy=1`. on_t=0 with en=1 → no strobes and `busy=0`.
- Read-back: CSRRS CTRL with rs1_data=0 returns the current CTRL with no write. A read of unmapped `Addr+2` returns 0. CTRL[31:2] reads 0 after a CSRRW of 0xFFFF_FFFF.
- Mid-phase TIME rewrite from on_t=10 to on_t=2 during ON → current phase lasts 10 ticks; the following ON phase lasts 2 ticks.

Source files
------------

// File: rtl/csr_led_blink_if.sv
// Operand/opcode package and the CSR-side bundle of the LED blink sequencer.
// The bundle carries the CSR instruction inputs, the read data and the LED external write port.
package csr_led_blink_pkg;
    typedef enum logic [2:0] {
        CSR_RW  = 3'd0,
        CSR_RS  = 3'd1,
        CSR_RC  = 3'd2,
        CSR_RWI = 3'd3,
        CSR_RSI = 3'd4,
        CSR_RCI = 3'd5
    } csr_op_t;
endpackage

interface csr_led_blink_if;
    import csr_led_blink_pkg::*;

    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_zimm;
    logic [31:0] rs1_data;
    csr_op_t     csr_op;
    logic [31:0] out;
    logic        ext_data;
    logic        ext_write_enable;
    logic        busy;

    modport master (
        output csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op,
        input  out, ext_data, ext_write_enable, busy
    );

    modport slave (
        input  csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op,
        output out, ext_data, ext_write_enable, busy
    );
endinterface

// File: rtl/csr_led_blink.sv
// CSR-programmable LED blink sequencer: CTRL/TIME registers plus an IDLE/ON/OFF
// phase machine that issues one-cycle write strobes to the LED CSR on each level change.
module csr_led_blink
    import csr_led_blink_pkg::*;
#(
    parameter logic [11:0] Addr     = 12'h001,
    parameter int unsigned Prescale = 1
) (
    input  logic           clk,
    input  logic           reset,
    csr_led_blink_if.slave bus
);
    localparam int unsigned       PrescW    = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [11:0]       TimeAddr  = Addr + 12'd1;
    localparam logic [PrescW-1:0] PrescLast = PrescW'(Prescale - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

    logic [1:0]        r_ctrl;
    logic [31:0]       r_time;
    state_t            r_state, w_state_nxt;
    logic [PrescW-1:0] r_presc, w_presc_nxt;
    logic [15:0]       r_cnt, w_cnt_nxt;
    logic              r_ext_data, r_ext_we, r_busy;
    logic              w_data_nxt, w_we_nxt;
    logic              w_ctrl_sel, w_time_sel, w_wr;
    logic [31:0]       w_src, w_old, w_new;
    logic              w_en, w_inv, w_tick, w_phase_end;
    logic [15:0]       w_on_t, w_off_t;

    // CSR decode, operand select and read-modify-write value
    always_comb begin
        w_ctrl_sel = bus.csr_enable && (bus.csr_addr == Addr);
        w_time_sel = bus.csr_enable && (bus.csr_addr == TimeAddr);
        w_old      = w_ctrl_sel ? {30'd0, r_ctrl} : (w_time_sel ? r_time : 32'd0);
        w_src      = bus.rs1_data;
        if (bus.csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI}) w_src = {27'd0, bus.rs1_zimm};
        w_new = w_old;
        w_wr  = 1'b0;
        case (bus.csr_op)
            CSR_RW, CSR_RWI: begin w_new = w_src;          w_wr = 1'b1;            end
            CSR_RS, CSR_RSI: begin w_new = w_old | w_src;  w_wr = (w_src != 32'd0); end
            CSR_RC, CSR_RCI: begin w_new = w_old & ~w_src; w_wr = (w_src != 32'd0); end
            default: ;
        endcase
    end

    assign bus.out = w_old;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
            r_time <= '0;
        end else if (w_wr) begin
            if (w_ctrl_sel) r_ctrl <= w_new[1:0];
            if (w_time_sel) r_time <= w_new;
        end
    end

    assign w_en    = r_ctrl[0];
    assign w_inv   = r_ctrl[1];
    assign w_on_t  = r_time[15:0];
    assign w_off_t = r_time[31:16];

    // Phase machine: counters reload on every phase load so TIME edits apply next phase
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_cnt_nxt   = r_cnt;
        w_tick      = (r_presc == PrescLast);
        w_phase_end = w_tick && (r_cnt <= 16'd1);
        if (!w_en) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_on_t != 16'd0) begin
                        w_state_nxt = ST_ON;
                        w_presc_nxt = '0;
                        w_cnt_nxt   = w_on_t;
                    end
                end
                ST_ON, ST_OFF: begin
                    if (w_phase_end) begin
                        w_presc_nxt = '0;
                        if (r_state == ST_ON) begin
                            w_state_nxt = (w_off_t != 16'd0) ? ST_OFF : ST_ON;
                            w_cnt_nxt   = (w_off_t != 16'd0) ? w_off_t : w_on_t;
                        end else begin
                            w_state_nxt = (w_on_t != 16'd0) ? ST_ON : ST_OFF;
                            w_cnt_nxt   = (w_on_t != 16'd0) ? w_on_t : w_off_t;
                        end
                    end else if (w_tick) begin
                        w_presc_nxt = '0;
                        w_cnt_nxt   = r_cnt - 16'd1;
                    end else begin
                        w_presc_nxt = r_presc + PrescW'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        w_we_nxt   = (w_state_nxt != r_state);
        w_data_nxt = w_we_nxt ? ((w_state_nxt == ST_ON) ^ w_inv) : r_ext_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_cnt      <= '0;
            r_ext_we   <= 1'b0;
            r_ext_data <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ext_we   <= w_we_nxt;
            r_ext_data <= w_data_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.ext_write_enable = r_ext_we;
    assign bus.ext_data         = r_ext_data;
    assign bus.busy             = r_busy;
endmodule
